// File: rtl/rr_index_arbiter_pkg.sv
// Shared arbiter types: FSM encoding and the index wrap helper.
// Also used by the decoder-side bench.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int unsigned next_idx(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_index_arbiter_if.sv
// Request/grant bundle between requesters and the index arbiter.
// The slave side is the arbiter itself.
interface rr_index_arbiter_if #(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic                 done;
    logic [IDX_WIDTH-1:0] dout;
    logic                 dout_v;
    logic                 timeout;

    modport master (
        output req, done,
        input  dout, dout_v, timeout
    );

    modport slave (
        input  req, done,
        output dout, dout_v, timeout
    );
endinterface

// File: rtl/rr_index_arbiter_pick.sv
// Rotating-priority search: first set request at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);
    localparam int SW = IDX_WIDTH + 1;
    localparam logic [SW-1:0] NR = SW'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [SW-1:0]      off;
    logic [SW-1:0]      sum;

    always_comb begin
        // Doubled vector shifted by ptr puts ptr at bit 0 with wrap built in.
        rot   = NUM_REQ'({req, req} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SW'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        idx = IDX_WIDTH'((sum >= NR) ? sum - NR : sum);
    end
endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter: registered grant index with hold timeout.
// Grant ends on done, request drop, or MAX_HOLD cycles.
module rr_index_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = $clog2(NUM_REQ),
    parameter int MAX_HOLD  = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_index_arbiter_if.slave  bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [IDX_WIDTH-1:0] dout_q, dout_d;
    logic                 dout_v_q, dout_v_d;
    logic                 timeout_q, timeout_d;

    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_found;
    logic                 cur_req;
    logic                 at_max;
    logic                 rel;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            dout_q    <= '0;
            dout_v_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            dout_q    <= dout_d;
            dout_v_q  <= dout_v_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        cur_req = bus.req[dout_q];
        at_max  = (hold_q == LAST);
        rel     = (state_q == ST_GRANT) &&
                  (bus.done || !cur_req || at_max);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_GRANT;
            ST_GRANT: if (rel)        state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        dout_d    = dout_q;
        dout_v_d  = dout_v_q;
        timeout_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                dout_d   = pick_idx;
                dout_v_d = 1'b1;
                hold_d   = '0;
            end
        end else if (rel) begin
            dout_v_d  = 1'b0;
            hold_d    = '0;
            ptr_d     = IDX_WIDTH'(next_idx(32'(dout_q),
                                            32'(NUM_REQ)));
            // Pulse only when the cap alone ended the grant.
            timeout_d = at_max && !bus.done && cur_req;
        end else begin
            hold_d = hold_q + HW'(1);
        end
    end

    assign bus.dout    = dout_q;
    assign bus.dout_v  = dout_v_q;
    assign bus.timeout = timeout_q;
endmodule
